// File: rtl/spi_pkg.sv
// Shared definitions for the byte-wide SPI masters: speed codes, FSM states
// and reset constants.
package spi_pkg;

  localparam logic [1:0] SPI_SPD_DIV2  = 2'd0;
  localparam logic [1:0] SPI_SPD_DIV4  = 2'd1;
  localparam logic [1:0] SPI_SPD_DIV8  = 2'd2;
  localparam logic [1:0] SPI_SPD_DIV16 = 2'd3;

  localparam logic [7:0] SPI_DOUT_RST = 8'hFF;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_LOW,
    SPI_HIGH
  } spi_state_t;

  // Terminal count of the half-period counter: H-1 where H = 1 << spd.
  function automatic logic [2:0] spi_half_last(input logic [1:0] spd);
    logic [2:0] last;
    case (spd)
      SPI_SPD_DIV2:  last = 3'd0;
      SPI_SPD_DIV4:  last = 3'd1;
      SPI_SPD_DIV8:  last = 3'd3;
      default:       last = 3'd7;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/spi_halfper_tick.sv
// Half-period timer for the SPI master: one-cycle tick every H = 1 << spd
// cycles, restarting from zero while clr is high.
module spi_halfper_tick
  import spi_pkg::*;
(
  input  logic       cpu_clock,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [1:0] spd,
  output logic       tick
);

  logic [2:0] cnt;

  assign tick = (cnt == spi_half_last(spd));

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// Byte-wide SPI mode-0 master: one byte out (MSB first) and one byte in per
// accepted start strobe, with a selectable half-period of 1/2/4/8 cycles.
module spi_byte_master
  import spi_pkg::*;
(
  input  logic       cpu_clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic [1:0] speed,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  spi_state_t state, state_nxt;
  logic [7:0] sr;
  logic [7:0] sr_shift;
  logic [2:0] bcnt;
  logic [1:0] spd_l;
  logic       tick;
  logic       accept;
  logic       rise;
  logic       fall;
  logic       last;

  // Holding the timer clear through IDLE guarantees it starts at zero on the
  // accept edge, so the first sck rise lands exactly H cycles later.
  spi_halfper_tick u_tick (
    .cpu_clock (cpu_clock),
    .rst_n     (rst_n),
    .clr       (state == SPI_IDLE),
    .spd       (spd_l),
    .tick      (tick)
  );

  assign sr_shift = {sr[6:0], miso};

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= SPI_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    last      = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SPI_LOW;
        end
      end
      SPI_LOW: begin
        if (tick) begin
          rise      = 1'b1;
          state_nxt = SPI_HIGH;
        end
      end
      SPI_HIGH: begin
        if (tick) begin
          fall      = 1'b1;
          last      = (bcnt == 3'd7);
          state_nxt = last ? SPI_IDLE : SPI_LOW;
        end
      end
      default: state_nxt = SPI_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= SPI_DOUT_RST;
      dout  <= SPI_DOUT_RST;
      bcnt  <= '0;
      spd_l <= SPI_SPD_DIV2;
      sck   <= 1'b0;
      mosi  <= 1'b1;
      rdy   <= 1'b1;
    end else begin
      if (accept) begin
        sr    <= din;
        spd_l <= speed;
        mosi  <= din[7];
        bcnt  <= '0;
        rdy   <= 1'b0;
      end
      if (rise) begin
        sck <= 1'b1;
      end
      // miso is sampled on the falling edge, i.e. at the end of the high phase.
      if (fall) begin
        sck  <= 1'b0;
        sr   <= sr_shift;
        mosi <= sr[6];
        bcnt <= bcnt + 3'd1;
        if (last) begin
          dout <= sr_shift;
          rdy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master: stimulus pushes the expected result of
// each transfer, a monitor measures every completed transfer and compares.
module tb_spi_byte_master;
  import spi_pkg::*;

  logic       cpu_clock;
  logic       rst_n;
  logic       start;
  logic [7:0] din;
  logic [1:0] speed;
  logic [7:0] dout;
  logic       rdy;
  logic       sck;
  logic       mosi;
  logic       miso;

  logic       loopback;
  logic [7:0] slave_sr;

  typedef struct {
    logic [7:0]  dout;
    logic [7:0]  mosi_bits;
    int unsigned dur;
    int unsigned hi;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_vec;
  int unsigned n_miss;
  int unsigned n_done;

  spi_byte_master dut (
    .cpu_clock (cpu_clock),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .speed     (speed),
    .dout      (dout),
    .rdy       (rdy),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso)
  );

  initial cpu_clock = 1'b0;
  always #5 cpu_clock = ~cpu_clock;

  assign miso = loopback ? mosi : slave_sr[7];

  // Slave presents its next bit after each falling sck edge.
  always @(negedge sck) begin
    if (!loopback) slave_sr = {slave_sr[6:0], 1'b0};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: measures each busy window and compares it against the queue.
  logic        busy;
  logic        sck_prev;
  int unsigned m_cyc;
  int unsigned m_hi;
  int unsigned m_rises;
  logic [7:0]  m_bits;

  initial begin
    busy = 1'b0;
    sck_prev = 1'b0;
    m_cyc = 0;
    m_hi = 0;
    m_rises = 0;
    m_bits = '0;
  end

  always @(negedge cpu_clock) begin
    exp_t e;
    if (!rst_n) begin
      busy = 1'b0;
    end else if (!rdy) begin
      if (!busy) begin
        busy = 1'b1;
        m_cyc = 0;
        m_hi = 0;
        m_rises = 0;
        m_bits = '0;
      end
      m_cyc++;
      if (sck) m_hi++;
      if (sck && !sck_prev) begin
        m_rises++;
        m_bits = {m_bits[6:0], mosi};
      end
    end else if (busy) begin
      busy = 1'b0;
      n_done++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_transfer: got dout %0h, expected no transfer", dout);
      end else begin
        e = exp_q.pop_front();
        check("dout", dout, e.dout);
        check("mosi_bits", m_bits, e.mosi_bits);
        check("sck_rises", m_rises, 8);
        check("busy_cycles", m_cyc, e.dur);
        check("sck_high_cycles", m_hi, e.hi);
      end
    end
    sck_prev = sck;
  end

  task automatic issue(input logic [7:0] b, input logic [1:0] s, input logic push,
                       input logic [7:0] exp_dout, input int unsigned h);
    exp_t e;
    @(negedge cpu_clock);
    start = 1'b1;
    din   = b;
    speed = s;
    if (push) begin
      e.dout = exp_dout;
      e.mosi_bits = b;
      e.dur = 16 * h;
      e.hi = 8 * h;
      exp_q.push_back(e);
    end
    @(negedge cpu_clock);
    start = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge cpu_clock);
      if (rdy) return;
    end
    n_vec++;
    n_miss++;
    $display("FAIL %s: got rdy stuck low, expected rdy within 400 cycles", name);
  endtask

  initial begin
    exp_t e;
    int unsigned sck_hi;
    int unsigned rises;
    logic        sp;

    n_vec = 0;
    n_miss = 0;
    n_done = 0;
    rst_n = 1'b0;
    start = 1'b0;
    din = '0;
    speed = SPI_SPD_DIV2;
    loopback = 1'b1;
    slave_sr = '0;

    repeat (3) @(negedge cpu_clock);
    check("rst_rdy", rdy, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 1);
    check("rst_dout", dout, 8'hFF);

    rst_n = 1'b1;
    sck_hi = 0;
    repeat (20) begin
      @(negedge cpu_clock);
      if (sck) sck_hi++;
    end
    check("idle_sck_activity", sck_hi, 0);
    check("idle_rdy", rdy, 1);
    check("idle_mosi", mosi, 1);
    check("idle_dout", dout, 8'hFF);

    // Loopback at fastest speed.
    issue(8'hA5, SPI_SPD_DIV2, 1'b1, 8'hA5, 1);
    wait_rdy("a5_done");

    // Slave returns 3C at slowest speed.
    loopback = 1'b0;
    slave_sr = 8'h3C;
    issue(8'h00, SPI_SPD_DIV16, 1'b1, 8'h3C, 8);
    wait_rdy("slave_done");
    loopback = 1'b1;

    // Start while busy must be ignored.
    issue(8'h81, SPI_SPD_DIV4, 1'b1, 8'h81, 2);
    repeat (3) @(negedge cpu_clock);
    start = 1'b1;
    din = 8'hFF;
    @(negedge cpu_clock);
    start = 1'b0;
    wait_rdy("busy_start_done");

    // Speed change mid-transfer, then back-to-back start in the rdy cycle.
    issue(8'h69, SPI_SPD_DIV2, 1'b1, 8'h69, 1);
    speed = SPI_SPD_DIV8;
    wait_rdy("b2b_first_done");
    start = 1'b1;
    din = 8'hC3;
    e.dout = 8'hC3;
    e.mosi_bits = 8'hC3;
    e.dur = 64;
    e.hi = 32;
    exp_q.push_back(e);
    @(negedge cpu_clock);
    start = 1'b0;
    check("b2b_no_gap", rdy, 0);
    wait_rdy("b2b_second_done");

    // Reset after the third sck rise aborts the transfer.
    issue(8'h96, SPI_SPD_DIV2, 1'b0, 8'h00, 1);
    rises = 0;
    sp = sck;
    for (int i = 0; i < 40 && rises < 3; i++) begin
      if (sck && !sp) rises++;
      sp = sck;
      if (rises < 3) @(negedge cpu_clock);
    end
    check("abort_rises_seen", rises, 3);
    rst_n = 1'b0;
    #1;
    check("abort_sck", sck, 0);
    check("abort_rdy", rdy, 1);
    check("abort_dout", dout, 8'hFF);
    check("abort_mosi", mosi, 1);
    repeat (2) @(negedge cpu_clock);
    rst_n = 1'b1;
    issue(8'h5A, SPI_SPD_DIV2, 1'b1, 8'h5A, 1);
    wait_rdy("post_reset_done");

    repeat (5) @(negedge cpu_clock);
    check("queue_drained", exp_q.size(), 0);
    check("transfers_done", n_done, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
